// File: rtl/c157x_gcr_shifter_if.sv
// c157x_gcr_shifter_if: head-stage and VIA-side signals of the GCR shifter.
// master drives ce/mode/hclk/hf/soe/din and observes ht/dout/sync_n/byte_n;
// slave is the shifter itself.
interface c157x_gcr_shifter_if;
    logic       ce;
    logic       mode;
    logic       hclk;
    logic       hf;
    logic       ht;
    logic       soe;
    logic [7:0] din;
    logic [7:0] dout;
    logic       sync_n;
    logic       byte_n;
    modport master (output ce, mode, hclk, hf, soe, din, input ht, dout, sync_n, byte_n);
    modport slave (input ce, mode, hclk, hf, soe, din, output ht, dout, sync_n, byte_n);
endinterface

// File: rtl/c157x_gcr_shifter.sv
// c157x_gcr_shifter: 1541/157x read/write bit-to-byte shifter with GCR SYNC detect.
// Ports: clk, reset_n (async, active low); bus (slave) carries ce, mode (1=read),
// hclk/hf head strobe and bit, ht write bit, soe, din, dout, sync_n, byte_n.
// Optional macro C157X_SYNC_COUNT_EN adds the 16-bit sync_cnt output.
// BYTE_PULSE sets the byte_n low time in clk cycles (1..15).
module c157x_gcr_shifter #(
    parameter int BYTE_PULSE = 2
) (
    input logic clk,
    input logic reset_n,
    c157x_gcr_shifter_if.slave bus
`ifdef C157X_SYNC_COUNT_EN
    ,
    output logic [15:0] sync_cnt
`endif
);
    logic       mode_q;
    logic [9:0] rsr;
    logic [7:0] wsr;
    logic [7:0] dout;
    logic [2:0] bit_cnt;
    logic [3:0] tmr;
    logic       ht;
    logic       sync_n;
    logic       byte_n;
    logic       bit_ev;
    logic       mode_chg;
    logic       ht_nxt;
    logic [9:0] rsr_nxt;
    logic       all1;
    logic       byte_ev;

    assign bus.ht     = ht;
    assign bus.dout   = dout;
    assign bus.sync_n = sync_n;
    assign bus.byte_n = byte_n;

    // In write mode rsr follows the written bit so SYNC writes look like reads.
    always_comb begin
        bit_ev   = bus.ce & bus.hclk;
        mode_chg = bus.mode != mode_q;
        ht_nxt   = bit_cnt == 3'd0 ? bus.din[7] : wsr[~bit_cnt];
        rsr_nxt  = {rsr[8:0], bus.mode ? bus.hf : ht_nxt};
        all1     = &rsr_nxt;
        byte_ev  = bit_ev & ~mode_chg & (bus.mode ? (bit_cnt == 3'd7) & ~all1 : bit_cnt == 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= 1'b1;
            rsr     <= '0;
            wsr     <= '0;
            dout    <= '0;
            bit_cnt <= '0;
            tmr     <= '0;
            ht      <= 1'b0;
            sync_n  <= 1'b1;
            byte_n  <= 1'b1;
        end else begin
            mode_q <= bus.mode;
            if (mode_chg) begin
                bit_cnt <= '0;
                rsr     <= '0;
                sync_n  <= 1'b1;
            end else if (bit_ev) begin
                rsr <= rsr_nxt;
                if (bus.mode) begin
                    sync_n  <= ~all1;
                    bit_cnt <= all1 ? 3'd0 : bit_cnt + 3'd1;
                    if (byte_ev)
                        dout <= rsr_nxt[7:0];
                end else begin
                    sync_n  <= 1'b1;
                    ht      <= ht_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd0)
                        wsr <= bus.din;
                end
            end
            // A new byte event reloads the timer, stretching a running pulse.
            if (byte_ev && bus.soe) begin
                byte_n <= 1'b0;
                tmr    <= BYTE_PULSE[3:0];
            end else if (!bus.soe && !byte_n) begin
                byte_n <= 1'b1;
                tmr    <= '0;
            end else if (tmr == 4'd1) begin
                byte_n <= 1'b1;
                tmr    <= '0;
            end else if (tmr != 4'd0) begin
                tmr <= tmr - 4'd1;
            end
        end
    end

`ifdef C157X_SYNC_COUNT_EN
    // Read: count sync_n falling; write: count rsr becoming all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sync_cnt <= '0;
        else if (bit_ev && !mode_chg && all1 && (bus.mode ? sync_n : ~&rsr))
            sync_cnt <= sync_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_c157x_gcr_shifter.sv
// tb_c157x_gcr_shifter: scoreboard bench for the GCR shifter.
module tb_c157x_gcr_shifter;
    typedef struct {
        logic [7:0] d;
        int         w;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    logic exp_ht[$];
    logic bev_s = 1'b0;
    logic mode_s = 1'b1;
    logic prev_bn = 1'b1;
    logic active = 1'b0;
    int   width = 0;
    ev_t  cur;
    logic [7:0] a5 = 8'hA5;
`ifdef C157X_SYNC_COUNT_EN
    logic [15:0] sync_cnt;
`endif

    c157x_gcr_shifter_if b();

    c157x_gcr_shifter #(.BYTE_PULSE(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(b)
`ifdef C157X_SYNC_COUNT_EN
        ,
        .sync_cnt(sync_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic bit_s(input logic v, input logic es, input logic drop);
        @(negedge clk);
        b.hclk = 1'b1;
        b.hf = v;
        @(negedge clk);
        b.hclk = 1'b0;
        if (drop)
            b.soe = 1'b0;
        chk("sync_n", {15'd0, b.sync_n}, {15'd0, es});
        @(negedge clk);
    endtask

    task automatic ones(input int n, input int k);
        for (int i = 1; i <= n; i++)
            bit_s(1'b1, i < k, 1'b0);
    endtask

    task automatic byte_rd(input logic [7:0] v, input logic drop);
        for (int i = 7; i >= 0; i--)
            bit_s(v[i], 1'b1, drop && i == 0);
    endtask

    always @(posedge clk) begin
        bev_s = b.ce & b.hclk & reset_n;
        mode_s = b.mode;
    end

    always @(negedge clk) begin
        if (bev_s && !mode_s) begin
            if (exp_ht.size() == 0)
                chk("ht_unexpected", 16'd1, 16'd0);
            else
                chk("ht", {15'd0, b.ht}, {15'd0, exp_ht.pop_front()});
        end
        if (!b.byte_n && prev_bn) begin
            if (exp_q.size() == 0) begin
                chk("byte_n_unexpected", {8'd0, b.dout}, 16'hFFFF);
                cur.d = b.dout;
                cur.w = 0;
            end else begin
                cur = exp_q.pop_front();
                chk("dout", {8'd0, b.dout}, {8'd0, cur.d});
            end
            width = 1;
            active = 1'b1;
        end else if (!b.byte_n) begin
            width++;
        end else if (!prev_bn && active) begin
            chk("byte_n_width", width[15:0], cur.w[15:0]);
            active = 1'b0;
        end
        prev_bn = b.byte_n;
    end

    initial begin
        b.ce = 1'b1;
        b.mode = 1'b1;
        b.hclk = 1'b0;
        b.hf = 1'b0;
        b.soe = 1'b1;
        b.din = 8'h00;
        @(negedge clk);
        chk("rst_dout", {8'd0, b.dout}, 16'h0000);
        chk("rst_ht", {15'd0, b.ht}, 16'h0000);
        chk("rst_sync_n", {15'd0, b.sync_n}, 16'h0001);
        chk("rst_byte_n", {15'd0, b.byte_n}, 16'h0001);
`ifdef C157X_SYNC_COUNT_EN
        chk("rst_sync_cnt", sync_cnt, 16'h0000);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        // 12 ones: 8th completes an $FF byte, 10th starts SYNC; then $52.
        exp_q.push_back('{8'hFF, 2});
        exp_q.push_back('{8'h52, 2});
        ones(12, 10);
        byte_rd(8'h52, 1'b0);
        // Stream: 10 ones (FF byte then sync), $55, $AA.
        exp_q.push_back('{8'hFF, 2});
        exp_q.push_back('{8'h55, 2});
        exp_q.push_back('{8'hAA, 2});
        ones(10, 10);
        byte_rd(8'h55, 1'b0);
        byte_rd(8'hAA, 1'b0);
        // soe=0: dout updates, no pulse.
        b.soe = 1'b0;
        byte_rd(8'h52, 1'b0);
        chk("dout_soe0", {8'd0, b.dout}, 16'h0052);
        // soe dropped mid-pulse cuts it to one cycle.
        b.soe = 1'b1;
        exp_q.push_back('{8'h33, 1});
        byte_rd(8'h33, 1'b1);
        b.soe = 1'b1;
        // Write $A5 for 16 bit events.
        @(negedge clk);
        b.mode = 1'b0;
        b.din = 8'hA5;
        @(negedge clk);
        exp_q.push_back('{8'h33, 2});
        exp_q.push_back('{8'h33, 2});
        for (int i = 0; i < 16; i++) begin
            exp_ht.push_back(a5[7 - (i % 8)]);
            bit_s(1'b0, 1'b1, 1'b0);
        end
        b.mode = 1'b1;
        @(negedge clk);
        // Reset after 4 bits of a byte.
        bit_s(1'b1, 1'b1, 1'b0);
        bit_s(1'b0, 1'b1, 1'b0);
        bit_s(1'b1, 1'b1, 1'b0);
        bit_s(1'b0, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_dout", {8'd0, b.dout}, 16'h0000);
        chk("arst_ht", {15'd0, b.ht}, 16'h0000);
        chk("arst_sync_n", {15'd0, b.sync_n}, 16'h0001);
        chk("arst_byte_n", {15'd0, b.byte_n}, 16'h0001);
`ifdef C157X_SYNC_COUNT_EN
        chk("arst_sync_cnt", sync_cnt, 16'h0000);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back('{8'hC3, 2});
        byte_rd(8'hC3, 1'b0);
        // ce=0: five head strobes must be ignored entirely.
        b.ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b.hclk = 1'b1;
            b.hf = 1'b1;
            @(negedge clk);
            b.hclk = 1'b0;
        end
        chk("ce0_dout", {8'd0, b.dout}, 16'h00C3);
        chk("ce0_sync_n", {15'd0, b.sync_n}, 16'h0001);
        b.ce = 1'b1;
        exp_q.push_back('{8'h1E, 2});
        byte_rd(8'h1E, 1'b0);
        // Three SYNC marks separated by data.
        for (int g = 0; g < 3; g++) begin
            exp_q.push_back('{8'hFF, 2});
            exp_q.push_back('{8'h52, 2});
            ones(10, 10);
            byte_rd(8'h52, 1'b0);
        end
`ifdef C157X_SYNC_COUNT_EN
        chk("sync_cnt", sync_cnt, 16'd3);
`endif
        repeat (10) @(negedge clk);
        chk("exp_q_left", exp_q.size(), 16'd0);
        chk("exp_ht_left", exp_ht.size(), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
